// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, requests words from a 1-cycle IMEM, and buffers them in 2 entries for IF/ID.
// Latency: request in cycle N gives IF_Valid in N+2, or N+1 when FETCH_BYPASS_EN is defined.
// Backpressure: Stall holds the head entry; issue stops once buffered plus inflight words reach 2.
module if_fetch_unit #(
   parameter logic [29:0] RESET_PC   = 30'h0000C00,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [29:0] RedirectPC,
   output logic        IM_Req,
   output logic [29:0] IM_Addr,
   input  logic [31:0] IM_Data,
   output logic [31:0] IF,
   output logic [29:0] PC_IF,
   output logic        IF_Valid
);

   logic [29:0] fetch_pc_q, fetch_pc_d;
   logic [29:0] req_pc_q, req_pc_d;
   logic [29:0] last_pc_q;
   logic        inflight_q, inflight_d;
   logic        drop_q, drop_d;
   logic        head_q, head_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] instr_q [FIFO_DEPTH];
   logic [29:0] pc_q    [FIFO_DEPTH];

   logic        fifo_vld, rsp_vld, byp, pop, fifo_pop, push, push_en, tail;
   logic [2:0]  occ;

   assign fifo_vld = (count_q != 2'd0);
   assign rsp_vld  = inflight_q & ~drop_q;
   assign tail     = head_q ^ count_q[0];

`ifdef FETCH_BYPASS_EN
   // An arriving word may feed IF/ID directly while the buffer is empty.
   assign byp = ~fifo_vld & rsp_vld;
`else
   assign byp = 1'b0;
`endif

   assign IF_Valid = fifo_vld | byp;
   assign pop      = IF_Valid & ~Stall & ~Redirect;
   assign fifo_pop = pop & fifo_vld;
   assign push     = rsp_vld & ~(byp & pop);
   assign push_en  = push & ~Redirect;

   always_comb begin
      IF    = 32'h0;
      PC_IF = last_pc_q;
      if (fifo_vld) begin
         IF    = instr_q[head_q];
         PC_IF = pc_q[head_q];
      end else if (byp) begin
         IF    = IM_Data;
         PC_IF = req_pc_q;
      end
   end

   // Occupancy after this cycle's pop must leave room for one more response.
   assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign IM_Req  = Rst_n & ~Redirect & (occ <= 3'd1);
   assign IM_Addr = fetch_pc_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = IM_Req;
      drop_d     = 1'b0;
      head_d     = head_q;
      count_d    = count_q;
      if (IM_Req) begin
         fetch_pc_d = fetch_pc_q + 30'd1;
         req_pc_d   = fetch_pc_q;
      end
      if (Redirect) begin
         fetch_pc_d = RedirectPC;
         drop_d     = inflight_d;
         count_d    = 2'd0;
      end else begin
         count_d = count_q + {1'b0, push} - {1'b0, fifo_pop};
         head_d  = head_q ^ fifo_pop;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         last_pc_q  <= RESET_PC;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         head_q     <= 1'b0;
         count_q    <= 2'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            instr_q[i] <= 32'h0;
            pc_q[i]    <= 30'h0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         last_pc_q  <= PC_IF;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         head_q     <= head_d;
         count_q    <= count_d;
         if (push_en) begin
            instr_q[tail] <= IM_Data;
            pc_q[tail]    <= req_pc_q;
         end
      end
   end

   a_count_bound: assert property (@(posedge Clk) disable iff (!Rst_n) count_q <= 2'd2);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: expected instruction stream queued by a sequential-PC model,
// popped and compared by a monitor whenever IF/ID consumes a word.
module tb_if_fetch_unit;

   localparam logic [29:0] RESET_PC = 30'h0000C00;
`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        Clk, Rst_n, Stall, Redirect;
   logic [29:0] RedirectPC, IM_Addr, PC_IF;
   logic        IM_Req, IF_Valid;
   logic [31:0] IM_Data, IF;

   if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
      .IM_Req(IM_Req), .IM_Addr(IM_Addr), .IM_Data(IM_Data),
      .IF(IF), .PC_IF(PC_IF), .IF_Valid(IF_Valid)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int nchk = 0;
   int npass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   // Instruction memory: one-cycle read latency, word = address xor a per-run salt.
   logic [31:0] salt;
   logic [29:0] mem_addr_q;
   logic        mem_vld_q;

   function automatic logic [31:0] word(input logic [29:0] a);
      return {2'b00, a} ^ salt;
   endfunction

   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) mem_vld_q <= 1'b0;
      else begin
         mem_vld_q <= IM_Req;
         if (IM_Req) mem_addr_q <= IM_Addr;
      end
   end
   assign IM_Data = mem_vld_q ? word(mem_addr_q) : 32'hDEADBEEF;

   // Reference model: consumed words form a consecutive PC sequence starting at the last redirect/reset target.
   typedef struct {
      logic [29:0] pc;
      logic [31:0] ins;
   } exp_t;
   exp_t        exp_q[$];
   logic [29:0] exp_next;

   task automatic sb_push();
      exp_t e;
      e.pc  = exp_next;
      e.ins = word(exp_next);
      exp_q.push_back(e);
      exp_next = exp_next + 30'd1;
   endtask

   task automatic sb_reset(input logic [29:0] pc);
      exp_q.delete();
      exp_next = pc;
      for (int i = 0; i < 8; i++) sb_push();
   endtask

   // Monitor
   logic        prev_pop, prev_hold;
   logic [31:0] prev_if;
   logic [29:0] prev_pc;
   initial begin
      prev_pop = 1'b0; prev_hold = 1'b0; prev_if = '0; prev_pc = RESET_PC;
   end

   always @(negedge Clk) begin
      if (!Rst_n) begin
         prev_pop  = 1'b0;
         prev_hold = 1'b0;
         prev_pc   = PC_IF;
         prev_if   = IF;
      end else begin
         if (prev_hold) begin
            chk("stall_hold_vld", IF_Valid, 1'b1);
            chk("stall_hold_if", IF, prev_if);
            chk("stall_hold_pc", PC_IF, prev_pc);
         end
         if (prev_pop) chk("no_bubble", IF_Valid, 1'b1);
         if (!IF_Valid) begin
            chk("empty_nop", IF, 32'h0);
            chk("empty_pc_hold", PC_IF, prev_pc);
         end
         if (IF_Valid && !Stall && !Redirect) begin
            if (exp_q.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("stream_pc", PC_IF, e.pc);
               chk("stream_if", IF, e.ins);
               sb_push();
            end
         end
         prev_hold = IF_Valid & Stall & ~Redirect;
         prev_pop  = IF_Valid & ~Stall & ~Redirect;
         prev_if   = IF;
         prev_pc   = PC_IF;
      end
   end

   task automatic step(input logic st, input logic rd, input logic [29:0] tgt);
      @(posedge Clk);
      #1;
      Stall      = st;
      Redirect   = rd;
      RedirectPC = tgt;
      if (rd) sb_reset(tgt);
   endtask

   // Counts cycles from the current one until IF_Valid rises; inputs stay as they are.
   task automatic chk_latency(input string name);
      int k;
      k = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         if (IF_Valid) begin
            k = i;
            break;
         end
         @(posedge Clk);
         #1;
      end
      chk(name, k, LAT);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $display("%0d/%0d checks passed", npass, nchk);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [29:0] tgt;
      Rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0; salt = 32'h0;
      exp_next = RESET_PC;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_vld", IF_Valid, 1'b0);
      chk("rst_if", IF, 32'h0);
      chk("rst_pc", PC_IF, RESET_PC);
      chk("rst_req", IM_Req, 1'b0);
      chk("rst_addr", IM_Addr, RESET_PC);

      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      sb_reset(RESET_PC);
      #1;
      chk("first_req", IM_Req, 1'b1);
      chk_latency("rst_latency");
      repeat (10) step(1'b0, 1'b0, '0);

      // Stall five cycles mid-stream.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, '0);
         if (i >= 1) begin
            #1;
            chk("stall_noreq", IM_Req, 1'b0);
         end
      end

      // Redirect on the release cycle with the buffer full.
      step(1'b0, 1'b1, 30'h100);
      #1;
      chk("redir_noreq", IM_Req, 1'b0);
      step(1'b0, 1'b0, '0);
      #1;
      chk("redir_addr", IM_Addr, 30'h100);
      chk("redir_req", IM_Req, 1'b1);
      chk_latency("redir_latency");
      repeat (8) step(1'b0, 1'b0, '0);

      // Redirect together with Stall.
      step(1'b1, 1'b1, 30'h200);
      repeat (4) step(1'b1, 1'b0, '0);
      repeat (8) step(1'b0, 1'b0, '0);

      // PC wrap at 2^30.
      step(1'b0, 1'b1, 30'h3FFFFFFD);
      repeat (10) step(1'b0, 1'b0, '0);

      // Back-to-back redirects: last target wins.
      step(1'b0, 1'b1, 30'h500);
      step(1'b0, 1'b1, 30'h600);
      repeat (8) step(1'b0, 1'b0, '0);

      // Asynchronous reset with a full buffer.
      repeat (3) step(1'b1, 1'b0, '0);
      #1;
      chk("full_before_rst", IF_Valid, 1'b1);
      @(posedge Clk);
      #3;
      Rst_n = 1'b0;
      #1;
      chk("arst_vld", IF_Valid, 1'b0);
      chk("arst_if", IF, 32'h0);
      chk("arst_pc", PC_IF, RESET_PC);
      chk("arst_req", IM_Req, 1'b0);
      salt = 32'h5A5A1234;
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      Stall = 1'b0;
      sb_reset(RESET_PC);
      chk_latency("rst2_latency");

      // Randomized stall/redirect traffic.
      for (int n = 0; n < 1500; n++) begin
         logic st, rd;
         st  = ($urandom % 4) == 0;
         rd  = ($urandom % 40) == 0;
         tgt = 30'($urandom);
         if (($urandom % 3) == 0) tgt = 30'h3FFFFFFC + 30'($urandom % 4);
         step(st, rd, tgt);
      end
      repeat (6) step(1'b0, 1'b0, '0);
      @(negedge Clk);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
